// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered, parametrised UART transmitter with overflow flag
// and a stretched activity LED. Frames are sent back to back while data is queued.
module uart_tx_fifo #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned LED_HOLD   = 65536
) (
    input  logic                          sys_clk_i,
    input  logic                          sys_rst_i,
    input  logic                          wr_en_i,
    input  logic [DATA_BITS-1:0]          wr_data_i,
    input  logic                          clr_ovf_i,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          busy_o,
    output logic                          overflow_o,
    output logic                          uart_tx,
    output logic                          tx_led
);

    localparam int unsigned DIV = CLK_FREQ / BAUD;
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned LW  = AW + 1;
    localparam int unsigned CW  = $clog2(DIV);
    localparam int unsigned BW  = $clog2(DATA_BITS);
    localparam int unsigned LCW = (LED_HOLD == 0) ? 1 : $clog2(LED_HOLD + 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    logic                 ovf_q, ovf_d;

    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        baud_q, baud_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic [LCW-1:0]       led_cnt_q, led_cnt_d;
    logic                 led_q, led_d;

    logic                 push;
    logic                 pop;
    logic                 baud_end;

    // FIFO bookkeeping: a push to a full FIFO is rejected even when a pop happens
    always_comb begin
        push     = wr_en_i & ~full_q;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q + LW'(push) - LW'(pop);
        full_d   = (level_d == LW'(FIFO_DEPTH));
        empty_d  = (level_d == '0);
        ovf_d    = ovf_q;
        if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end
        if (wr_en_i && full_q) begin
            ovf_d = 1'b1;
        end
    end

    // Frame sequencer: next state, bit timing and pop decision
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        pop      = 1'b0;
        baud_end = (baud_q == CW'(DIV - 1));

        if (state_q != ST_IDLE) begin
            baud_d = baud_end ? '0 : baud_q + CW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (!empty_q) begin
                    pop     = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (baud_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BW'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (baud_end) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (baud_end) begin
                    if (bit_q == BW'(STOP_BITS - 1)) begin
                        bit_d = '0;
                        // chain straight into the next frame when data is waiting
                        if (!empty_q) begin
                            pop     = 1'b1;
                            state_d = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (pop) begin
            shift_d = mem_q[rd_ptr_q];
            par_d   = (^mem_q[rd_ptr_q]) ^ (PARITY == 1);
        end
    end

    // Line level, busy flag and LED stretch, all registered
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_q[0];
            ST_PARITY: tx_d = par_q;
            default:   tx_d = 1'b1;
        endcase
        busy_d = (state_q != ST_IDLE);
        if (busy_q) begin
            led_cnt_d = LCW'(LED_HOLD);
        end else if (led_cnt_q != '0) begin
            led_cnt_d = led_cnt_q - LCW'(1);
        end else begin
            led_cnt_d = led_cnt_q;
        end
        led_d = busy_d | (led_cnt_d != '0);
    end

    // Control and status registers
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            ovf_q     <= 1'b0;
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            led_cnt_q <= '0;
            led_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            led_cnt_q <= led_cnt_d;
            led_q     <= led_d;
        end
    end

    // FIFO storage; contents are don't-care after reset since pointers clear
    always_ff @(posedge sys_clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign level_o    = level_q;
    assign busy_o     = busy_q;
    assign overflow_o = ovf_q;
    assign uart_tx    = tx_q;
    assign tx_led     = led_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: three uart_tx_fifo configurations (8N1, 8E2, 8O2) share one
// stimulus stream; a queue-and-frame-timer model predicts every output each cycle.
module tb_uart_tx_fifo;

    localparam int DIV      = 10;
    localparam int LED_HOLD = 50;
    localparam int DEPTH    = 16;
    localparam int NI       = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       wr_en;
    logic       clr_ovf;
    logic [7:0] wr_data;

    logic [NI-1:0] full_w, empty_w, busy_w, ovf_w, tx_w, led_w;
    logic [4:0]    level_w [NI];

    int   n_checks = 0;
    int   n_errors = 0;
    logic chk_on   = 1'b0;

    uart_tx_fifo #(.CLK_FREQ(50000000), .BAUD(5000000), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(16), .LED_HOLD(50)) u_dut_8n1 (
        .sys_clk_i(clk), .sys_rst_i(rst_n), .wr_en_i(wr_en), .wr_data_i(wr_data),
        .clr_ovf_i(clr_ovf), .full_o(full_w[0]), .empty_o(empty_w[0]), .level_o(level_w[0]),
        .busy_o(busy_w[0]), .overflow_o(ovf_w[0]), .uart_tx(tx_w[0]), .tx_led(led_w[0]));

    uart_tx_fifo #(.CLK_FREQ(50000000), .BAUD(5000000), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(2), .FIFO_DEPTH(16), .LED_HOLD(50)) u_dut_8e2 (
        .sys_clk_i(clk), .sys_rst_i(rst_n), .wr_en_i(wr_en), .wr_data_i(wr_data),
        .clr_ovf_i(clr_ovf), .full_o(full_w[1]), .empty_o(empty_w[1]), .level_o(level_w[1]),
        .busy_o(busy_w[1]), .overflow_o(ovf_w[1]), .uart_tx(tx_w[1]), .tx_led(led_w[1]));

    uart_tx_fifo #(.CLK_FREQ(50000000), .BAUD(5000000), .DATA_BITS(8), .PARITY(1),
                   .STOP_BITS(2), .FIFO_DEPTH(16), .LED_HOLD(50)) u_dut_8o2 (
        .sys_clk_i(clk), .sys_rst_i(rst_n), .wr_en_i(wr_en), .wr_data_i(wr_data),
        .clr_ovf_i(clr_ovf), .full_o(full_w[2]), .empty_o(empty_w[2]), .level_o(level_w[2]),
        .busy_o(busy_w[2]), .overflow_o(ovf_w[2]), .uart_tx(tx_w[2]), .tx_led(led_w[2]));

    // Compare one observed value against its expectation
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
        end
    endtask

    function automatic int par_of(input int k);
        if (k == 0) return 0;
        if (k == 1) return 2;
        return 1;
    endfunction

    function automatic int stop_of(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    function automatic int frame_len(input int k);
        return DIV * (1 + 8 + ((par_of(k) != 0) ? 1 : 0) + stop_of(k));
    endfunction

    // Bit number idx of the frame carrying byte d: start, LSB-first data, parity, stop
    function automatic logic frame_bit(input int k, input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (idx == 9 && par_of(k) != 0) return (par_of(k) == 2) ? (^d) : ~(^d);
        return 1'b1;
    endfunction

    // Reference model: a byte queue plus "cycles left in current frame" per instance
    logic [7:0] m_buf  [NI][DEPTH];
    int         m_head [NI];
    int         m_cnt  [NI];
    int         m_rem  [NI];
    int         m_idle [NI];
    logic [7:0] m_cur  [NI];
    logic       m_tx   [NI];
    logic       m_busy [NI];
    logic       m_ovf  [NI];
    int         m_widx;
    logic       m_full, m_empty;

    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (!rst_n) begin
                m_head[k] = 0;
                m_cnt[k]  = 0;
                m_rem[k]  = 0;
                m_idle[k] = LED_HOLD + 1;
                m_tx[k]   = 1'b1;
                m_busy[k] = 1'b0;
                m_ovf[k]  = 1'b0;
            end else begin
                // the line shows, one edge late, whatever the transmitter was sending
                m_tx[k]   = (m_rem[k] > 0) ?
                            frame_bit(k, m_cur[k], (frame_len(k) - m_rem[k]) / DIV) : 1'b1;
                m_busy[k] = (m_rem[k] > 0);
                m_full    = (m_cnt[k] == DEPTH);
                m_empty   = (m_cnt[k] == 0);
                m_widx    = (m_head[k] + m_cnt[k]) % DEPTH;
                if (wr_en && m_full) m_ovf[k] = 1'b1;
                else if (clr_ovf)    m_ovf[k] = 1'b0;
                if (!m_empty && m_rem[k] <= 1) begin
                    m_cur[k]  = m_buf[k][m_head[k]];
                    m_head[k] = (m_head[k] + 1) % DEPTH;
                    m_cnt[k]  = m_cnt[k] - 1;
                    m_rem[k]  = frame_len(k);
                end else if (m_rem[k] > 0) begin
                    m_rem[k] = m_rem[k] - 1;
                end
                if (wr_en && !m_full) begin
                    m_buf[k][m_widx] = wr_data;
                    m_cnt[k]         = m_cnt[k] + 1;
                end
                if (m_busy[k]) m_idle[k] = 0;
                else if (m_idle[k] <= LED_HOLD) m_idle[k] = m_idle[k] + 1;
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < NI; k++) begin
                chk($sformatf("tx%0d", k),    32'(tx_w[k]),    32'(m_tx[k]));
                chk($sformatf("busy%0d", k),  32'(busy_w[k]),  32'(m_busy[k]));
                chk($sformatf("led%0d", k),   32'(led_w[k]),   32'(m_busy[k] || m_idle[k] <= LED_HOLD));
                chk($sformatf("ovf%0d", k),   32'(ovf_w[k]),   32'(m_ovf[k]));
                chk($sformatf("full%0d", k),  32'(full_w[k]),  32'(m_cnt[k] == DEPTH));
                chk($sformatf("empty%0d", k), 32'(empty_w[k]), 32'(m_cnt[k] == 0));
                chk($sformatf("level%0d", k), 32'(level_w[k]), 32'(m_cnt[k]));
            end
        end
    end

    task automatic push_seq(input logic [31:0] bytes, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = bytes[8*i +: 8];
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Wait for instance k to go busy, then record mid-bit line samples and busy length
    task automatic sample_frame(input int k, output logic [15:0] bits, output int len);
        int t;
        bits = '0;
        len  = 0;
        t    = 0;
        while (!busy_w[k] && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("busy_rise%0d", k), 32'(busy_w[k]), 32'd1);
        while (busy_w[k] && len < 1000) begin
            if (len % DIV == 5 && len / DIV < 16) bits[4'(len / DIV)] = tx_w[k];
            len++;
            @(negedge clk);
        end
    endtask

    task automatic led_tail(input int k, output int n);
        n = 0;
        while (led_w[k] && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((!(&empty_w) || (|busy_w)) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 32'((&empty_w) && !(|busy_w)), 32'd1);
    endtask

    initial begin
        logic [15:0] bits;
        int          len;
        int          n;
        int          t;
        logic        seen;

        rst_n   = 1'b0;
        wr_en   = 1'b0;
        clr_ovf = 1'b0;
        wr_data = 8'h00;

        // reset held for 20 cycles
        repeat (20) @(negedge clk);
        chk_on = 1'b1;
        for (int k = 0; k < NI; k++) begin
            chk("rst_tx",    32'(tx_w[k]),    32'd1);
            chk("rst_empty", 32'(empty_w[k]), 32'd1);
            chk("rst_level", 32'(level_w[k]), 32'd0);
            chk("rst_busy",  32'(busy_w[k]),  32'd0);
            chk("rst_led",   32'(led_w[k]),   32'd0);
            chk("rst_ovf",   32'(ovf_w[k]),   32'd0);
        end
        rst_n = 1'b1;

        // single 8N1 frame of 0xA5 and the LED tail after it
        push_seq(32'hA5, 1);
        sample_frame(0, bits, len);
        chk("a5_len",  32'(len),        32'd100);
        chk("a5_bits", 32'(bits[9:0]),  32'({1'b1, 8'hA5, 1'b0}));
        led_tail(0, n);
        chk("a5_led",  32'(n),          32'd50);
        wait_drain();

        // even parity, two stop bits, then odd parity
        push_seq(32'h07, 1);
        sample_frame(1, bits, len);
        chk("e2_len",  32'(len),        32'd120);
        chk("e2_bits", 32'(bits[11:0]), 32'({2'b11, 1'b1, 8'h07, 1'b0}));
        wait_drain();
        push_seq(32'h07, 1);
        sample_frame(2, bits, len);
        chk("o2_len",  32'(len),        32'd120);
        chk("o2_bits", 32'(bits[11:0]), 32'({2'b11, 1'b0, 8'h07, 1'b0}));
        wait_drain();

        // 18-cycle burst: 17 accepted, last one dropped
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = 8'(i);
        end
        @(negedge clk);
        wr_en = 1'b0;
        for (int k = 0; k < NI; k++) begin
            chk("burst_ovf",   32'(ovf_w[k]),   32'd1);
            chk("burst_level", 32'(level_w[k]), 32'd16);
            chk("burst_full",  32'(full_w[k]),  32'd1);
        end
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        for (int k = 0; k < NI; k++) chk("clr_ovf", 32'(ovf_w[k]), 32'd0);
        wait_drain();

        // back-to-back frames: second start bit right after the first stop bit
        push_seq(32'hAA55, 2);
        sample_frame(0, bits, len);
        chk("b2b_len",  32'(len),  32'd200);
        chk("b2b_bits", 32'(bits), 32'({5'b01010, 1'b0, 1'b1, 8'h55, 1'b0}));
        led_tail(0, n);
        chk("b2b_led",  32'(n),    32'd50);
        wait_drain();

        // reset during data bit 3 with three bytes still queued
        push_seq(32'h332211C3, 4);
        t = 0;
        while (!busy_w[0] && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (44) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("abort_tx",    32'(tx_w[k]),    32'd1);
            chk("abort_level", 32'(level_w[k]), 32'd0);
            chk("abort_busy",  32'(busy_w[k]),  32'd0);
        end
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (300) begin
            @(negedge clk);
            seen = seen | (|busy_w);
        end
        chk("abort_quiet", 32'(seen), 32'd0);

        // randomized traffic with sporadic clears and resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_data = 8'($urandom);
            clr_ovf = ($urandom_range(0, 59) == 0);
            rst_n   = ($urandom_range(0, 999) != 0);
        end
        @(negedge clk);
        wr_en   = 1'b0;
        clr_ovf = 1'b0;
        rst_n   = 1'b1;
        wait_drain();
        repeat (60) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
